// File: rtl/enemy_terrain_probe_if.sv
// Tile-map ROM bus between the terrain probe (master) and the map ROM (slave).
interface enemy_terrain_probe_if;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TILE_W = 2;

  logic [ADDR_W-1:0] map_addr;
  logic              map_rd;
  logic [TILE_W-1:0] map_data;

  modport master (
    output map_addr,
    output map_rd,
    input  map_data
  );

  modport slave (
    input  map_addr,
    input  map_rd,
    output map_data
  );
endinterface

// File: rtl/enemy_terrain_probe.sv
// Enemy terrain probe: on each frame strobe, reads the tile under the enemy's
// body and the tile under its feet, then updates walk/climb permissions.
module enemy_terrain_probe (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic [9:0]            EnemyX,
  input  logic [9:0]            EnemyY,
  enemy_terrain_probe_if.master map,
  output logic                  walk,
  output logic                  climb,
  output logic                  probe_done,
  output logic                  overrun
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TILE_W  = 2;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MAX_COL = 23;
  localparam int unsigned MAX_ROW = 18;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    RD_BODY,
    RD_FOOT,
    WAIT_FOOT,
    COMMIT
  } state_t;

  // Tile address of a pixel point: clamped (row, col) folded to row*24 + col.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [POS_W-1:0] px,
                                                  input logic [POS_W-1:0] py);
    logic [POS_W-1:0] cx;
    logic [POS_W-1:0] ry;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row;
    cx  = px >> 3;
    ry  = py >> 3;
    col = (cx > POS_W'(MAX_COL)) ? IDX_W'(MAX_COL) : cx[IDX_W-1:0];
    row = (ry > POS_W'(MAX_ROW)) ? IDX_W'(MAX_ROW) : ry[IDX_W-1:0];
    return (ADDR_W'(row) << 4) + (ADDR_W'(row) << 3) + ADDR_W'(col);
  endfunction

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, hist_q;
  logic                warm1_q, warm2_q;
  logic                rise_c;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W-1:0]   body_addr_c, foot_addr_c;
  logic [ADDR_W-1:0]   foot_addr_q, foot_addr_d;
  logic [ADDR_W-1:0]   map_addr_q, map_addr_d;
  logic                map_rd_q, map_rd_d;
  logic                body_ladder_q, body_ladder_d;
  logic [TILE_W-1:0]   foot_tile_q, foot_tile_d;
  logic                walk_q, walk_d;
  logic                climb_q, climb_d;
  logic                probe_done_q, probe_done_d;

  // Synchronize frame_clk; history stays high until the chain carries real
  // samples, so a strobe already high at reset release is not seen as a rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      warm1_q <= 1'b0;
      warm2_q <= 1'b0;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      warm1_q <= 1'b1;
      warm2_q <= warm1_q;
      hist_q  <= warm2_q ? sync2_q : hist_q;
    end
  end

  assign rise_c = sync2_q & ~hist_q;

  // Probe points from the live position; only sampled in SNAP.
  always_comb begin
    body_addr_c = tile_addr(EnemyX + POS_W'(4), EnemyY + POS_W'(4));
    foot_addr_c = tile_addr(EnemyX + POS_W'(4), EnemyY + POS_W'(8));
  end

  // Next-state, request bookkeeping and ROM sequencing.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    foot_addr_d   = foot_addr_q;
    map_addr_d    = map_addr_q;
    map_rd_d      = 1'b0;
    body_ladder_d = body_ladder_q;
    foot_tile_d   = foot_tile_q;
    walk_d        = walk_q;
    climb_d       = climb_q;
    probe_done_d  = 1'b0;

    if (rise_c && (state_q != IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise_c || pending_q) begin
          state_d   = SNAP;
          // A fresh rise coinciding with a consumed pending request stays queued.
          pending_d = rise_c && pending_q;
        end
      end
      SNAP: begin
        state_d     = RD_BODY;
        foot_addr_d = foot_addr_c;
        map_addr_d  = body_addr_c;
        map_rd_d    = 1'b1;
      end
      RD_BODY: begin
        state_d    = RD_FOOT;
        map_addr_d = foot_addr_q;
        map_rd_d   = 1'b1;
      end
      RD_FOOT: begin
        state_d       = WAIT_FOOT;
        body_ladder_d = map.map_data[1];
      end
      WAIT_FOOT: begin
        state_d     = COMMIT;
        foot_tile_d = map.map_data;
      end
      COMMIT: begin
        state_d      = IDLE;
        walk_d       = foot_tile_q[0];
        climb_d      = body_ladder_q | foot_tile_q[1];
        probe_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any probe in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      foot_addr_q   <= '0;
      map_addr_q    <= '0;
      map_rd_q      <= 1'b0;
      body_ladder_q <= 1'b0;
      foot_tile_q   <= '0;
      walk_q        <= 1'b0;
      climb_q       <= 1'b0;
      probe_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      foot_addr_q   <= foot_addr_d;
      map_addr_q    <= map_addr_d;
      map_rd_q      <= map_rd_d;
      body_ladder_q <= body_ladder_d;
      foot_tile_q   <= foot_tile_d;
      walk_q        <= walk_d;
      climb_q       <= climb_d;
      probe_done_q  <= probe_done_d;
    end
  end

  assign map.map_addr = map_addr_q;
  assign map.map_rd   = map_rd_q;
  assign walk         = walk_q;
  assign climb        = climb_q;
  assign probe_done   = probe_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_enemy_terrain_probe.sv
// Directed bench for enemy_terrain_probe with a synchronous tile-map ROM model.
module tb_enemy_terrain_probe;

  logic       Clk       = 1'b0;
  logic       Reset_n   = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] EnemyX    = '0;
  logic [9:0] EnemyY    = '0;
  logic       walk, climb, probe_done, overrun;

  logic [1:0] rom [512];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int start_cnt;

  enemy_terrain_probe_if bus();

  enemy_terrain_probe dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .EnemyX     (EnemyX),
    .EnemyY     (EnemyY),
    .map        (bus),
    .walk       (walk),
    .climb      (climb),
    .probe_done (probe_done),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data appears the cycle after a read strobe.
  always @(posedge Clk) if (bus.map_rd) bus.map_data <= rom[bus.map_addr];

  // Count probe_done pulses.
  always @(posedge Clk) if (probe_done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One frame strobe; checks the cycle-exact ROM sequence and commit timing.
  // Edge k is the first edge seeing frame_clk high; detection is after edge k+1.
  task automatic do_probe(input string tag, input logic [8:0] ab, input logic [8:0] af,
                          input bit move_x);
    frame_clk = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      tick();
      case (c)
        0: frame_clk = 1'b0;
        2: check_eq({tag, "_snap_rd"}, 32'(bus.map_rd), 32'd0);
        3: begin
          check_eq({tag, "_body_rd"},   32'(bus.map_rd),   32'd1);
          check_eq({tag, "_body_addr"}, 32'(bus.map_addr), 32'(ab));
          if (move_x) EnemyX = 10'd8;
        end
        4: begin
          check_eq({tag, "_foot_rd"},   32'(bus.map_rd),   32'd1);
          check_eq({tag, "_foot_addr"}, 32'(bus.map_addr), 32'(af));
        end
        5: begin
          check_eq({tag, "_wait_rd"},   32'(bus.map_rd),   32'd0);
          check_eq({tag, "_addr_hold"}, 32'(bus.map_addr), 32'(af));
        end
        6: check_eq({tag, "_done_early"}, 32'(probe_done), 32'd0);
        7: check_eq({tag, "_done"},       32'(probe_done), 32'd1);
        8: check_eq({tag, "_done_pulse"}, 32'(probe_done), 32'd0);
        default: ;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 2'b00;

    // Reset state
    tick(); tick();
    check_eq("rst_walk",     32'(walk),         32'd0);
    check_eq("rst_climb",    32'(climb),        32'd0);
    check_eq("rst_done",     32'(probe_done),   32'd0);
    check_eq("rst_rd",       32'(bus.map_rd),   32'd0);
    check_eq("rst_addr",     32'(bus.map_addr), 32'd0);
    check_eq("rst_overrun",  32'(overrun),      32'd0);
    Reset_n = 1'b1;
    repeat (3) tick();

    // Nominal probe; EnemyX moved during RD_BODY must not disturb the addresses
    rom[157] = 2'b00; rom[181] = 2'b01;
    EnemyX = 10'd100; EnemyY = 10'd50;
    do_probe("nom", 9'd157, 9'd181, 1'b1);
    check_eq("nom_walk",  32'(walk),  32'd1);
    check_eq("nom_climb", 32'(climb), 32'd0);
    check_eq("nom_count", 32'(done_cnt), 32'd1);
    repeat (3) tick();
    check_eq("nom_walk_hold", 32'(walk), 32'd1);

    // Ladder in the body tile
    rom[157] = 2'b10; rom[181] = 2'b00;
    EnemyX = 10'd100; EnemyY = 10'd50;
    do_probe("lad", 9'd157, 9'd181, 1'b0);
    check_eq("lad_walk",  32'(walk),  32'd0);
    check_eq("lad_climb", 32'(climb), 32'd1);
    repeat (3) tick();

    // Clamp at the map corner
    rom[455] = 2'b11;
    EnemyX = 10'd200; EnemyY = 10'd150;
    do_probe("clamp", 9'd455, 9'd455, 1'b0);
    check_eq("clamp_walk",    32'(walk),    32'd1);
    check_eq("clamp_climb",   32'(climb),   32'd1);
    check_eq("clamp_overrun", 32'(overrun), 32'd0);
    repeat (3) tick();

    // Reset during WAIT_FOOT aborts; strobe high at release starts nothing
    EnemyX = 10'd100; EnemyY = 10'd50;
    start_cnt = done_cnt;
    frame_clk = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      if (c == 0) frame_clk = 1'b0;
    end
    frame_clk = 1'b1;
    Reset_n = 1'b0;
    #1;
    check_eq("abort_walk",  32'(walk),         32'd0);
    check_eq("abort_climb", 32'(climb),        32'd0);
    check_eq("abort_rd",    32'(bus.map_rd),   32'd0);
    check_eq("abort_addr",  32'(bus.map_addr), 32'd0);
    check_eq("abort_done",  32'(probe_done),   32'd0);
    tick(); tick();
    Reset_n = 1'b1;
    repeat (10) tick();
    check_eq("release_no_probe", 32'(done_cnt - start_cnt), 32'd0);
    check_eq("release_walk",     32'(walk),                 32'd0);
    frame_clk = 1'b0;
    repeat (3) tick();

    // Next real rising edge does probe
    rom[157] = 2'b00; rom[181] = 2'b01;
    do_probe("post_rst", 9'd157, 9'd181, 1'b0);
    check_eq("post_rst_walk", 32'(walk), 32'd1);
    repeat (3) tick();

    // Back-to-back: second rise in RD_FOOT queues, third in COMMIT overruns
    start_cnt = done_cnt;
    frame_clk = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      case (c)
        0: frame_clk = 1'b0;
        2: frame_clk = 1'b1;
        3: begin
          frame_clk = 1'b0;
          check_eq("b2b_first_addr", 32'(bus.map_addr), 32'd157);
        end
        4: frame_clk = 1'b1;
        5: check_eq("b2b_no_overrun", 32'(overrun), 32'd0);
        6: frame_clk = 1'b0;
        7: begin
          check_eq("b2b_first_done", 32'(probe_done), 32'd1);
          check_eq("b2b_overrun",    32'(overrun),    32'd1);
        end
        9: begin
          check_eq("b2b_second_rd",   32'(bus.map_rd),   32'd1);
          check_eq("b2b_second_addr", 32'(bus.map_addr), 32'd157);
        end
        13: check_eq("b2b_second_done", 32'(probe_done), 32'd1);
        16: begin
          check_eq("b2b_pulses",        32'(done_cnt - start_cnt), 32'd2);
          check_eq("b2b_overrun_stick", 32'(overrun),              32'd1);
        end
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_terrain_probe.md
ENEMY_TERRAIN_PROBE -- requirements
Module: enemy_terrain_probe

Interface
REQ-001 Clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 frame_clk  input  1  frame strobe; asynchronous to Clk; each rising edge requests one probe.
REQ-004 EnemyX  input  10  enemy column in halved screen units, valid range 0..192.
REQ-005 EnemyY  input  10  enemy row in halved screen units, valid range 0..148.
REQ-006 map_addr  output  9  tile-map ROM address, computed as row*24 + col.
REQ-007 map_rd  output  1  ROM read strobe.
REQ-008 map_data  input  2  tile code from a synchronous ROM, valid in the cycle after map_rd.
- bit0 = floor.
- bit1 = ladder.
REQ-009 walk  output  1  registered; the enemy may move horizontally.
REQ-010 climb  output  1  registered; the enemy may move vertically.
REQ-011 probe_done  output  1  one-cycle pulse when walk and climb update.
REQ-012 overrun  output  1  sticky flag; a frame request was dropped.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer, followed by an edge-history flop; a rise is detected when the synchronized value is 1 and the history value is 0.
REQ-014 States SHALL be: IDLE, SNAP, RD_BODY, RD_FOOT, WAIT_FOOT, COMMIT; each non-IDLE state SHALL last exactly 1 cycle.
REQ-015 Transitions SHALL be as follows.
- IDLE -> SNAP on a detected rise or a pending request.
- SNAP -> RD_BODY -> RD_FOOT -> WAIT_FOOT -> COMMIT -> IDLE, unconditionally.
REQ-016 SNAP SHALL capture EnemyX and EnemyY; the rest of the probe SHALL use only the captured values.
REQ-017 SNAP SHALL compute two probe points.
- Body point: (EnemyX+4, EnemyY+4).
- Foot point: (EnemyX+4, EnemyY+8).
REQ-018 Tile coordinates SHALL be computed as follows.
- col = point_x >> 3, clamped to 23.
- row = point_y >> 3, clamped to 18.
- Arithmetic is 10-bit; no wrap occurs for inputs in range.
REQ-019 The row*24 term SHALL be formed as (row<<4)+(row<<3), giving 9-bit addresses 0..455.
REQ-020 RD_BODY SHALL drive map_rd=1 with map_addr = body address.
REQ-021 RD_FOOT SHALL drive map_rd=1 with map_addr = foot address, and SHALL capture map_data as the body tile.
REQ-022 WAIT_FOOT SHALL drive map_rd=0 and SHALL capture map_data as the foot tile.
REQ-023 COMMIT SHALL update the outputs atomically and pulse probe_done=1.
- walk <= foot[0].
- climb <= body[1] | foot[1].
REQ-024 Outside RD_BODY and RD_FOOT, map_rd SHALL be 0 and map_addr SHALL hold its last value.
REQ-025 Between COMMITs, walk and climb SHALL hold their values.
REQ-026 Latency: if a rise is detected in cycle D, SNAP SHALL occur in D+1 and COMMIT in D+5, with new outputs visible from D+6.
REQ-027 A rise detected while the FSM is not in IDLE SHALL set a single pending flag.
REQ-028 A rise detected while pending is already set SHALL set overrun=1; that request is dropped.
REQ-029 The pending flag SHALL be cleared on entry to SNAP.
REQ-030 A rise detected in the COMMIT cycle SHALL count as pending, so that SNAP follows immediately after IDLE.
REQ-031 overrun SHALL clear only on reset.

Reset
REQ-032 While Reset_n=0, all of the following SHALL be forced.
- FSM = IDLE.
- walk=0, climb=0, probe_done=0, map_rd=0, map_addr=0, overrun=0.
- pending=0.
- Captured tiles = 0.
- Synchronizer flops = 0.
REQ-033 The edge-history flop SHALL reset to 1, so that frame_clk being high at reset release starts no probe.
REQ-034 Reset asserted mid-probe SHALL abort the probe immediately; no probe_done pulse and no output update SHALL occur.

Verification
REQ-035 Nominal probe: EnemyX=100, EnemyY=50, ROM[157]=2'b00, ROM[181]=2'b01 -> map_addr sequence 157 then 181 with map_rd high for 2 cycles; then walk=1, climb=0, one probe_done pulse.
REQ-036 Ladder: EnemyX=100, EnemyY=50, ROM[157]=2'b10, ROM[181]=2'b00 -> walk=0, climb=1.
REQ-037 Clamp: EnemyX=200, EnemyY=150 -> both reads use address 455; no address exceeds 455.
REQ-038 Latency and snapshot: EnemyX changes from 100 to 8 during RD_BODY -> addresses remain 157 and 181; COMMIT occurs exactly 5 cycles after the detection cycle.
REQ-039 Back-to-back requests: a second rise during RD_FOOT -> a second probe runs immediately after, overrun=0; a third rise before the second probe's SNAP -> overrun=1, and only 2 probe_done pulses occur.
REQ-040 Reset: Reset_n pulled low during WAIT_FOOT with walk previously 1 -> walk=0, climb=0, map_rd=0 immediately; release with frame_clk=1 -> no probe until the next rising edge of frame_clk.
